// File: rtl/mult_pkg.sv
// Shared definitions for the shift-add multiplier controller and datapath.
// Holds the state encoding and its width so the datapath bench can decode
// the controller state with the same constants.
package mult_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_ADD   = 3'd2,
        ST_SHIFT = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/mult_seq_ctrl_if.sv
// Handshake and strobe bundle between the requester/datapath side and the
// multiplier sequencer.
//   start, abort      requester -> controller
//   mplier_lsb        datapath  -> controller
//   ld_regs, add_en,
//   shift_en          controller -> datapath strobes
//   busy, done, iter  controller -> requester status
interface mult_seq_ctrl_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH)
);
    logic             start;
    logic             abort;
    logic             mplier_lsb;
    logic             ld_regs;
    logic             add_en;
    logic             shift_en;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] iter;

    modport master (
        output start, abort, mplier_lsb,
        input  ld_regs, add_en, shift_en, busy, done, iter
    );

    modport slave (
        input  start, abort, mplier_lsb,
        output ld_regs, add_en, shift_en, busy, done, iter
    );
endinterface

// File: rtl/iter_counter.sv
// Iteration counter for the multiplier sequencer.
// Ports:
//   clk    system clock, rising edge
//   reset  asynchronous, active-low
//   i_clr  synchronous clear (wins over enable)
//   i_en   count up by one
//   o_cnt  current count, 0..WIDTH-1
//   o_tc   terminal count flag, high when o_cnt == WIDTH-1
module iter_counter #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_clr,
    input  logic             i_en,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_tc
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             w_tc;

    assign w_tc = (r_cnt == LAST);

    // Holding at terminal count means the counter can never wrap.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en && !w_tc) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_cnt = r_cnt;
    assign o_tc  = w_tc;

endmodule

// File: rtl/mult_seq_ctrl.sv
// Moore sequencer for the shift-add multiplier datapath. Issues one strobe
// per cycle (load, then WIDTH add/shift pairs) and handshakes via
// start/busy/done. No datapath lives here.
// Ports:
//   clk    system clock, rising edge
//   reset  asynchronous, active-low; forces IDLE
//   bus    mult_seq_ctrl_if slave: start/abort/mplier_lsb in,
//          ld_regs/add_en/shift_en/busy/done/iter out
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | waiting for start, all outputs low
//   LOAD  | ld_regs: load operands, clear accumulator, iteration = 0
//   ADD   | add_en follows mplier_lsb
//   SHIFT | shift_en; last iteration goes to DONE, else back to ADD
//   DONE  | one-cycle done pulse; start here restarts without dropping busy
module mult_seq_ctrl
    import mult_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic              clk,
    input  logic              reset,
    mult_seq_ctrl_if.slave    bus
);

    state_t           r_state;
    state_t           w_next;
    logic             r_ld_regs;
    logic             r_add_arm;
    logic             r_shift_en;
    logic             r_busy;
    logic             r_done;
    logic [CNT_W-1:0] w_iter;
    logic             w_tc;
    logic             w_cnt_clr;
    logic             w_cnt_en;

    always_comb begin
        w_next = ST_IDLE;
        case (r_state)
            ST_IDLE:  w_next = (bus.start && !bus.abort) ? ST_LOAD : ST_IDLE;
            ST_LOAD:  w_next = bus.abort ? ST_IDLE : ST_ADD;
            ST_ADD:   w_next = bus.abort ? ST_IDLE : ST_SHIFT;
            ST_SHIFT: w_next = bus.abort ? ST_IDLE : (w_tc ? ST_DONE : ST_ADD);
            ST_DONE:  w_next = bus.abort ? ST_IDLE : (bus.start ? ST_LOAD : ST_IDLE);
            default:  w_next = ST_IDLE;
        endcase
    end

    // Outputs are registered from the next-state value so they line up with
    // the state they belong to without any decode path from inputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_ld_regs  <= 1'b0;
            r_add_arm  <= 1'b0;
            r_shift_en <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_ld_regs  <= (w_next == ST_LOAD);
            r_add_arm  <= (w_next == ST_ADD);
            r_shift_en <= (w_next == ST_SHIFT);
            r_busy     <= (w_next != ST_IDLE);
            r_done     <= (w_next == ST_DONE);
        end
    end

    // Clearing on entry to IDLE or LOAD makes iter read 0 while idle, during
    // LOAD and after an abort; it holds WIDTH-1 through DONE.
    assign w_cnt_clr = (w_next == ST_IDLE) || (w_next == ST_LOAD);
    assign w_cnt_en  = (r_state == ST_SHIFT) && (w_next == ST_ADD);

    iter_counter #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_iter_counter (
        .clk   (clk),
        .reset (reset),
        .i_clr (w_cnt_clr),
        .i_en  (w_cnt_en),
        .o_cnt (w_iter),
        .o_tc  (w_tc)
    );

    // The add strobe is the one output that depends on a live input: the
    // multiplier LSB present during the ADD cycle, gated by the state flop.
    assign bus.ld_regs  = r_ld_regs;
    assign bus.add_en   = r_add_arm & bus.mplier_lsb;
    assign bus.shift_en = r_shift_en;
    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.iter     = w_iter;

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Directed bench for mult_seq_ctrl (WIDTH=8). Cycle c starts 1 time unit
// after a rising edge; inputs are driven there and outputs sampled 1 unit
// later. Cycle 0 is an IDLE cycle in which start is driven.
module tb_mult_seq_ctrl;

    localparam int WIDTH = 8;
    localparam int CNT_W = 3;
    // Multiplier bits per iteration, bit i = iteration i: 1,0,1,1,0,0,0,0
    localparam logic [7:0] PAT = 8'b0000_1101;

    typedef struct packed {
        logic       ld;
        logic       add;
        logic       sh;
        logic       busy;
        logic       done;
        logic [2:0] iter;
        logic       lsb;
    } ev_t;

    logic clk;
    logic reset;
    int   n_chk;
    int   n_fail;
    int   cyc;

    mult_seq_ctrl_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

    mult_seq_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, cyc, got, exp);
        end
    endtask

    // Hand-derived expectations. An operation whose LOAD is in cycle L has
    // ADD in L+1+2i, SHIFT in L+2+2i, DONE in L+17.
    // mode 0 normal, 1 start pulses while busy, 2 back-to-back,
    // 3 abort in cycle 9, 4 abort+start in IDLE.
    function automatic ev_t exp_at(input int mode, input int c);
        ev_t e;
        int  l;
        int  r;
        logic act;
        e = '0;
        e.lsb = 1'b1;
        l = (mode == 2 && c >= 19) ? 19 : 1;
        act = (mode != 4) && !(mode == 3 && c >= 10) && (c >= l) && (c <= l + 17);
        if (act) begin
            r = c - l;
            e.busy = 1'b1;
            e.ld   = (r == 0);
            e.done = (r == 17);
            e.sh   = (r >= 2) && (r <= 16) && (r % 2 == 0);
            if (r >= 1 && r <= 15 && (r % 2 == 1)) begin
                e.lsb = PAT[(r - 1) / 2];
                e.add = e.lsb;
            end
            if (r >= 1 && r <= 16) e.iter = 3'((r - 1) / 2);
            else if (r == 17)      e.iter = 3'd7;
        end
        return e;
    endfunction

    task automatic check_outs(input string nm, input ev_t e);
        chk({nm, "_ld"},    32'(bus.ld_regs),  32'(e.ld));
        chk({nm, "_add"},   32'(bus.add_en),   32'(e.add));
        chk({nm, "_shift"}, 32'(bus.shift_en), 32'(e.sh));
        chk({nm, "_busy"},  32'(bus.busy),     32'(e.busy));
        chk({nm, "_done"},  32'(bus.done),     32'(e.done));
        chk({nm, "_iter"},  32'(bus.iter),     32'(e.iter));
        chk({nm, "_excl"},  32'($countones({bus.ld_regs, bus.add_en, bus.shift_en}) <= 1), 32'd1);
    endtask

    task automatic run(input int mode, input int ncyc, input string nm);
        ev_t e;
        for (int c = 0; c < ncyc; c++) begin
            @(posedge clk);
            #1;
            cyc = c;
            e = exp_at(mode, c);
            bus.start = (c == 0) || (mode == 1 && (c == 5 || c == 10)) ||
                        (mode == 2 && c == 18);
            bus.abort = (mode == 3 && c == 9) || (mode == 4 && c == 0);
            bus.mplier_lsb = e.lsb;
            #1;
            check_outs(nm, e);
        end
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.mplier_lsb = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cycle=%0d got=timeout expected=finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        n_chk = 0;
        n_fail = 0;
        cyc = 0;
        reset = 1'b0;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.mplier_lsb = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        check_outs("reset", ev_t'(0));
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(posedge clk);

        run(0, 20, "norm");
        run(1, 20, "busy_start");
        run(2, 38, "b2b");
        run(3, 21, "abort");
        run(4, 5,  "abort_start");

        // Reset mid-SHIFT at iter=3 (cycle 9), outputs must drop at once.
        run(0, 10, "pre_rst");
        reset = 1'b0;
        #1;
        check_outs("async_rst", ev_t'(0));
        repeat (2) @(posedge clk);
        #1;
        check_outs("rst_hold", ev_t'(0));
        @(negedge clk);
        reset = 1'b1;
        run(0, 20, "post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
